// File: rtl/dlfloat_pair_tx_if.sv
// Operand/pin/result bundle for the DLfloat pair transmitter.
// master = upstream host and MAC-side driver, slave = the transmitter.
interface dlfloat_pair_tx_if #(
  parameter int DEPTH = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [15:0]             in_a;
  logic [15:0]             in_b;
  logic [15:0]             pin_data;
  logic                    pin_phase;
  logic                    pin_valid;
  logic [15:0]             res_in;
  logic                    res_valid;
  logic [15:0]             res_data;
  logic [$clog2(DEPTH):0]  level;
  logic                    busy;

  modport master (
    output in_valid, in_a, in_b, res_in,
    input  in_ready, pin_data, pin_phase, pin_valid, res_valid, res_data, level, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, res_in,
    output in_ready, pin_data, pin_phase, pin_valid, res_valid, res_data, level, busy
  );
endinterface

// File: rtl/dlfloat_pair_tx.sv
// Two-beat DLfloat operand transmitter: FIFO of (a,b) pairs, A/B pin slots locked to a free-running
// toggle, and fixed-latency result capture. Optional DLF_TX_ZERO_FILTER_EN drops zero-product pairs.
module dlfloat_pair_tx #(
  parameter int DEPTH   = 4,
  parameter int RES_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  dlfloat_pair_tx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE_A = 2'd0,
    IDLE_B = 2'd1,
    SEND_A = 2'd2,
    SEND_B = 2'd3
  } state_t;

  state_t               state;
  logic [15:0]          mem_a [DEPTH];
  logic [15:0]          mem_b [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        level_q;
  logic [LW-1:0]        level_next;
  logic                 in_ready_q;
  logic [15:0]          hold_b;
  logic [15:0]          pin_data_q;
  logic                 pin_phase_q;
  logic                 pin_valid_q;
  logic [RES_LAT-1:0]   tokens;
  logic                 res_valid_q;
  logic [15:0]          res_data_q;

  logic                 push;
  logic                 pop;
  logic                 drop;
  logic                 nonempty;
  logic                 head_zero;
  logic                 leave_b;
  logic [15:0]          head_a;
  logic [15:0]          head_b;

  always_comb begin
    head_a   = mem_a[rd_ptr];
    head_b   = mem_b[rd_ptr];
    nonempty = (level_q != '0);
    push     = bus.in_valid & in_ready_q;
    leave_b  = (state == IDLE_B) | (state == SEND_B);
`ifdef DLF_TX_ZERO_FILTER_EN
    // A zero-magnitude operand makes the product zero, so the pair is discarded from the head.
    head_zero = (head_a[14:0] == 15'd0) | (head_b[14:0] == 15'd0);
`else
    head_zero = 1'b0;
`endif
    drop       = nonempty & head_zero;
    pop        = nonempty & ~head_zero & leave_b;
    level_next = level_q + LW'(push) - LW'(pop | drop);
  end

  // Operand storage; entries are qualified by the pointers, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= bus.in_a;
      mem_b[wr_ptr] <= bus.in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE_A;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      in_ready_q  <= 1'b1;
      hold_b      <= 16'd0;
      pin_data_q  <= 16'd0;
      pin_phase_q <= 1'b0;
      pin_valid_q <= 1'b0;
      tokens      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= 16'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop | drop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level_q    <= level_next;
      in_ready_q <= (level_next != LW'(DEPTH));

      // Each B beat launches a token; its exit marks the cycle res_in carries that pair's result.
      tokens      <= (tokens << 1) | RES_LAT'(state == SEND_B);
      res_valid_q <= tokens[RES_LAT-1];
      if (tokens[RES_LAT-1]) begin
        res_data_q <= bus.res_in;
      end

      case (state)
        IDLE_A: begin
          state       <= IDLE_B;
          pin_phase_q <= 1'b1;
          pin_valid_q <= 1'b0;
          pin_data_q  <= 16'd0;
        end
        SEND_A: begin
          state       <= SEND_B;
          pin_phase_q <= 1'b1;
          pin_valid_q <= 1'b1;
          pin_data_q  <= hold_b;
        end
        IDLE_B, SEND_B: begin
          pin_phase_q <= 1'b0;
          if (pop) begin
            state       <= SEND_A;
            pin_valid_q <= 1'b1;
            pin_data_q  <= head_a;
            hold_b      <= head_b;
          end else begin
            state       <= IDLE_A;
            pin_valid_q <= 1'b0;
            pin_data_q  <= 16'd0;
          end
        end
        default: begin
          state       <= IDLE_A;
          pin_phase_q <= 1'b0;
          pin_valid_q <= 1'b0;
          pin_data_q  <= 16'd0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.pin_data  = pin_data_q;
  assign bus.pin_phase = pin_phase_q;
  assign bus.pin_valid = pin_valid_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.level     = level_q;
  assign bus.busy      = (level_q != '0) | (state == SEND_A) | (state == SEND_B) | (|tokens);
endmodule
